// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage types, widths and bus defines (REG_BUS, INST_BUS, INST_NOP, IF_STATE_*).
// No logic; imported by if_fetch.
`ifndef IF_FETCH_DEFINES
`define IF_FETCH_DEFINES
`define REG_BUS       63:0
`define INST_BUS      31:0
`define INST_NOP      32'h0000_0013
`define IF_STATE_BUS  1:0
`define IF_STATE_REQ  2'd0
`define IF_STATE_WAIT 2'd1
`define IF_STATE_OUT  2'd2
`define IF_STATE_DROP 2'd3
`endif

package if_fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [ILEN-1:0] INST_NOP     = `INST_NOP;

  typedef enum logic [`IF_STATE_BUS] {
    S_REQ  = `IF_STATE_REQ,
    S_WAIT = `IF_STATE_WAIT,
    S_OUT  = `IF_STATE_OUT,
    S_DROP = `IF_STATE_DROP
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: owns PC, one imem read in flight, holds instruction until decode takes it.
// Latency: request->inst_valid = resp latency + 1 (resp latency with IF_RESP_BYPASS_EN).
// Backpressure: inst_ready low holds the entry and blocks new requests; redirect always wins.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [ILEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst_data,
  output logic            inst_misalign
);

`ifdef IF_RESP_BYPASS_EN
  localparam bit RESP_BYPASS = 1'b1;
`else
  localparam bit RESP_BYPASS = 1'b0;
`endif

  if_state_e       state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] inst_pc_q, inst_pc_nxt;
  logic [ILEN-1:0] inst_data_q, inst_data_nxt;
  logic            misalign_q, misalign_nxt;
  logic [XLEN-1:0] pc_inc;
  logic            pc_aligned;

  assign pc_inc        = pc + XLEN'(4);
  assign pc_aligned    = (pc[1:0] == 2'b00);
  assign imem_req_addr = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_pc_nxt    = inst_pc_q;
    inst_data_nxt  = inst_data_q;
    misalign_nxt   = misalign_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    inst_pc        = inst_pc_q;
    inst_data      = inst_data_q;
    inst_misalign  = misalign_q;

    case (state)
      S_REQ: begin
        // A misaligned PC never reaches memory; it becomes an exception entry.
        imem_req_valid = !redirect_valid && pc_aligned;
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
        end else if (!pc_aligned) begin
          inst_pc_nxt   = pc;
          inst_data_nxt = INST_NOP;
          misalign_nxt  = 1'b1;
          state_nxt     = S_OUT;
        end else if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (RESP_BYPASS && imem_resp_valid) begin
          inst_valid    = !redirect_valid;
          inst_pc       = pc;
          inst_data     = imem_resp_data;
          inst_misalign = 1'b0;
        end
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid && RESP_BYPASS && inst_ready) begin
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end else if (imem_resp_valid) begin
          inst_pc_nxt   = pc;
          inst_data_nxt = imem_resp_data;
          misalign_nxt  = 1'b0;
          state_nxt     = S_OUT;
        end
      end

      S_OUT: begin
        inst_valid = 1'b1;
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_REQ;
        end else if (inst_ready) begin
          pc_nxt    = pc_inc;
          state_nxt = S_REQ;
        end
      end

      S_DROP: begin
        // Waiting out the response of a fetch that a redirect already killed.
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
        end else if (imem_resp_valid) begin
          state_nxt = S_REQ;
        end
      end

      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      inst_pc_q   <= inst_pc_nxt;
      inst_data_q <= inst_data_nxt;
      misalign_q  <= misalign_nxt;
    end
  end

endmodule
